// File: rtl/multi_wr_fifo_if.sv
// Nine-lane write / single-lane read bundle for multi_wr_fifo.
// drop_cnt exists only when MULTI_WR_FIFO_DROP_CNT_EN is defined.
interface multi_wr_fifo_if;
  logic [8:0] wen;
  logic [8:0] i_data0;
  logic [8:0] i_data1;
  logic [8:0] i_data2;
  logic [8:0] i_data3;
  logic [8:0] i_data4;
  logic [8:0] i_data5;
  logic [8:0] i_data6;
  logic [8:0] i_data7;
  logic [8:0] i_data8;
  logic       ren;
  logic       valid;
  logic [8:0] o_data;
  logic       freeze_clk;
  logic       ovf;
`ifdef MULTI_WR_FIFO_DROP_CNT_EN
  logic [7:0] drop_cnt;

  modport master (
    output wen, i_data0, i_data1, i_data2, i_data3, i_data4,
           i_data5, i_data6, i_data7, i_data8, ren,
    input  valid, o_data, freeze_clk, ovf, drop_cnt
  );

  modport slave (
    input  wen, i_data0, i_data1, i_data2, i_data3, i_data4,
           i_data5, i_data6, i_data7, i_data8, ren,
    output valid, o_data, freeze_clk, ovf, drop_cnt
  );
`else
  modport master (
    output wen, i_data0, i_data1, i_data2, i_data3, i_data4,
           i_data5, i_data6, i_data7, i_data8, ren,
    input  valid, o_data, freeze_clk, ovf
  );

  modport slave (
    input  wen, i_data0, i_data1, i_data2, i_data3, i_data4,
           i_data5, i_data6, i_data7, i_data8, ren,
    output valid, o_data, freeze_clk, ovf
  );
`endif
endinterface

// File: rtl/multi_wr_fifo.sv
// Nine-lane packing write / show-ahead single read circular FIFO with freeze_clk back-pressure.
// Optional saturating drop counter enabled by MULTI_WR_FIFO_DROP_CNT_EN.
module multi_wr_fifo #(
  parameter int NPORT   = 9,
  parameter int DW      = 9,
  parameter int DEPTH   = 32,
  parameter int FRZ_LVL = 9
) (
  input  logic           clk,
  input  logic           reset,
  multi_wr_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0]    mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             valid_r;
  logic [DW-1:0]    o_data_r;
  logic             freeze_r;
  logic             ovf_r;

  logic [DW-1:0]    lane_data_s [NPORT];
  logic [AW-1:0]    addr_s [NPORT];
  logic [NPORT-1:0] acc_s;
  logic [CW-1:0]    free_s;
  logic [CW-1:0]    n_req_s;
  logic [CW-1:0]    n_acc_s;
  logic [CW-1:0]    count_next_s;
  logic [AW-1:0]    wr_ptr_next_s;
  logic [AW-1:0]    rd_ptr_next_s;
  logic [DW-1:0]    o_data_next_s;
  logic             pop_s;
  logic             drop_s;

  // Gather the explicit lane ports into an indexable array
  always_comb begin
    lane_data_s[0] = bus.i_data0;
    lane_data_s[1] = bus.i_data1;
    lane_data_s[2] = bus.i_data2;
    lane_data_s[3] = bus.i_data3;
    lane_data_s[4] = bus.i_data4;
    lane_data_s[5] = bus.i_data5;
    lane_data_s[6] = bus.i_data6;
    lane_data_s[7] = bus.i_data7;
    lane_data_s[8] = bus.i_data8;
  end

  // Rank enabled lanes, accept those that fit, and derive next-state values
  always_comb begin
    free_s  = CW'(DEPTH) - count_r;
    n_req_s = '0;
    n_acc_s = '0;
    acc_s   = '0;
    for (int k = 0; k < NPORT; k++) begin
      addr_s[k] = wr_ptr_r + AW'(n_req_s);
      if (bus.wen[k]) begin
        // free is sampled before any same-cycle pop
        if (n_req_s < free_s) begin
          acc_s[k] = 1'b1;
          n_acc_s  = n_acc_s + CW'(1);
        end else begin
          acc_s[k] = 1'b0;
        end
        n_req_s = n_req_s + CW'(1);
      end else begin
        acc_s[k] = 1'b0;
      end
    end
    drop_s        = (n_acc_s != n_req_s);
    pop_s         = bus.ren & (count_r != CW'(0));
    count_next_s  = count_r + n_acc_s - CW'(pop_s);
    wr_ptr_next_s = wr_ptr_r + AW'(n_acc_s);
    rd_ptr_next_s = rd_ptr_r + AW'(pop_s);
    // The next head may be a word being written on this very edge
    o_data_next_s = mem_r[rd_ptr_next_s];
    for (int k = 0; k < NPORT; k++) begin
      o_data_next_s = (acc_s[k] && (addr_s[k] == rd_ptr_next_s)) ? lane_data_s[k] : o_data_next_s;
    end
  end

  // Buffer storage; contents need no reset
  always_ff @(posedge clk) begin
    for (int k = 0; k < NPORT; k++) begin
      if (acc_s[k]) begin
        mem_r[addr_s[k]] <= lane_data_s[k];
      end
    end
  end

  // Pointers, occupancy and registered status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      valid_r  <= 1'b0;
      o_data_r <= '0;
      freeze_r <= 1'b0;
      ovf_r    <= 1'b0;
    end else begin
      wr_ptr_r <= wr_ptr_next_s;
      rd_ptr_r <= rd_ptr_next_s;
      count_r  <= count_next_s;
      valid_r  <= (count_next_s != CW'(0));
      if (count_next_s != CW'(0)) begin
        o_data_r <= o_data_next_s;
      end else begin
        o_data_r <= o_data_r;
      end
      freeze_r <= (CW'(DEPTH) - count_next_s) < CW'(FRZ_LVL);
      ovf_r    <= ovf_r | drop_s;
    end
  end

  assign bus.valid      = valid_r;
  assign bus.o_data     = o_data_r;
  assign bus.freeze_clk = freeze_r;
  assign bus.ovf        = ovf_r;

`ifdef MULTI_WR_FIFO_DROP_CNT_EN
  logic [7:0] drop_cnt_r;
  logic [8:0] drop_sum_s;

  // Widen by one bit so saturation can be detected from the carry
  always_comb begin
    drop_sum_s = {1'b0, drop_cnt_r} + 9'(n_req_s - n_acc_s);
  end

  // Saturating count of dropped lane writes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_cnt_r <= 8'd0;
    end else begin
      drop_cnt_r <= drop_sum_s[8] ? 8'hFF : drop_sum_s[7:0];
    end
  end

  assign bus.drop_cnt = drop_cnt_r;
`endif
endmodule

// File: tb/tb_multi_wr_fifo.sv
// Bench for multi_wr_fifo: vector table plus queue scoreboard and hand-written corner sequences.
module tb_multi_wr_fifo;
  localparam int DEPTH = 32;
  localparam int FRZ   = 9;

  logic clk = 1'b0;
  logic reset;

  multi_wr_fifo_if bus ();

  multi_wr_fifo dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0]  wen;
    logic        ren;
    logic [80:0] data;
    logic        exp_valid;
    logic [8:0]  exp_data;
    logic        exp_freeze;
    logic        exp_ovf;
  } vec_t;

  vec_t        tbl [14];
  int          n_chk  = 0;
  int          n_fail = 0;
  logic [8:0]  q [$];
  bit          ovf_m  = 1'b0;
  int          drop_m = 0;
  logic [80:0] lanes  = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [8:0] w, input logic r);
    bus.wen     = w;
    bus.ren     = r;
    bus.i_data0 = lanes[8:0];
    bus.i_data1 = lanes[17:9];
    bus.i_data2 = lanes[26:18];
    bus.i_data3 = lanes[35:27];
    bus.i_data4 = lanes[44:36];
    bus.i_data5 = lanes[53:45];
    bus.i_data6 = lanes[62:54];
    bus.i_data7 = lanes[71:63];
    bus.i_data8 = lanes[80:72];
  endtask

  task automatic rand_lanes();
    for (int k = 0; k < 9; k++) lanes[k*9 +: 9] = 9'($urandom_range(0, 511));
  endtask

  // One clock: check head against scoreboard, update model, then check status after the edge
  task automatic cycle(input logic [8:0] w, input logic r);
    logic [8:0] acc [$];
    int free;
    int n;
    int drops;
    drive(w, r);
    chk("pre_valid", 32'(bus.valid), 32'(q.size() != 0));
    if (q.size() != 0) chk("head_data", 32'(bus.o_data), 32'(q[0]));
    free  = DEPTH - int'(q.size());
    n     = 0;
    drops = 0;
    for (int k = 0; k < 9; k++) begin
      if (w[k]) begin
        if (n < free) acc.push_back(lanes[k*9 +: 9]);
        else drops++;
        n++;
      end
    end
    if (r && q.size() != 0) void'(q.pop_front());
    foreach (acc[i]) q.push_back(acc[i]);
    if (drops > 0) ovf_m = 1'b1;
    drop_m = (drop_m + drops > 255) ? 255 : drop_m + drops;
    @(posedge clk);
    #1;
    chk("freeze", 32'(bus.freeze_clk), 32'((DEPTH - int'(q.size())) < FRZ));
    chk("ovf", 32'(bus.ovf), 32'(ovf_m));
`ifdef MULTI_WR_FIFO_DROP_CNT_EN
    chk("drop_cnt", 32'(bus.drop_cnt), 32'(drop_m));
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Vector table: full 9-lane burst drained, then sparse lanes 2/5/8
    for (int i = 0; i < 14; i++) begin
      tbl[i].wen = 9'h000; tbl[i].ren = 1'b1; tbl[i].data = '0;
      tbl[i].exp_freeze = 1'b0; tbl[i].exp_ovf = 1'b0;
    end
    tbl[0].wen = 9'h1FF; tbl[0].ren = 1'b0;
    for (int k = 0; k < 9; k++) tbl[0].data[k*9 +: 9] = 9'(16 + k);
    tbl[0].exp_valid = 1'b1; tbl[0].exp_data = 9'd16;
    for (int i = 1; i <= 9; i++) begin
      tbl[i].exp_valid = (i < 9);
      tbl[i].exp_data  = (i < 9) ? 9'(16 + i) : 9'd24;
    end
    tbl[10].wen = 9'b1_0010_0100; tbl[10].ren = 1'b0;
    tbl[10].data = {81{1'b1}};
    tbl[10].data[18 +: 9] = 9'h00A;
    tbl[10].data[45 +: 9] = 9'h00B;
    tbl[10].data[72 +: 9] = 9'h00C;
    tbl[10].exp_valid = 1'b1; tbl[10].exp_data = 9'h00A;
    tbl[11].exp_valid = 1'b1; tbl[11].exp_data = 9'h00B;
    tbl[12].exp_valid = 1'b1; tbl[12].exp_data = 9'h00C;
    tbl[13].exp_valid = 1'b0; tbl[13].exp_data = 9'h00C;

    reset = 1'b1;
    drive(9'h000, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_valid", 32'(bus.valid), 32'd0);
    chk("rst_data", 32'(bus.o_data), 32'd0);
    chk("rst_freeze", 32'(bus.freeze_clk), 32'd0);
    chk("rst_ovf", 32'(bus.ovf), 32'd0);
`ifdef MULTI_WR_FIFO_DROP_CNT_EN
    chk("rst_drop_cnt", 32'(bus.drop_cnt), 32'd0);
`endif

    for (int i = 0; i < 14; i++) begin
      lanes = tbl[i].data;
      cycle(tbl[i].wen, tbl[i].ren);
      chk("tbl_valid", 32'(bus.valid), 32'(tbl[i].exp_valid));
      chk("tbl_data", 32'(bus.o_data), 32'(tbl[i].exp_data));
      chk("tbl_freeze", 32'(bus.freeze_clk), 32'(tbl[i].exp_freeze));
      chk("tbl_ovf", 32'(bus.ovf), 32'(tbl[i].exp_ovf));
    end

    // Move both pointers to 30, then burst 4 across the wrap
    rand_lanes(); cycle(9'h1FF, 1'b1);
    rand_lanes(); cycle(9'h1FF, 1'b1);
    while (q.size() != 0) cycle(9'h000, 1'b1);
    rand_lanes(); cycle(9'h00F, 1'b0);
    chk("wrap_valid", 32'(bus.valid), 32'd1);
    chk("wrap_head", 32'(bus.o_data), 32'(lanes[8:0]));
    while (q.size() != 0) cycle(9'h000, 1'b1);

    // Freeze threshold around free = 9
    for (int i = 0; i < 3; i++) begin rand_lanes(); cycle(9'h1FF, 1'b0); end
    rand_lanes(); cycle(9'h001, 1'b0);
    chk("freeze_at_28", 32'(bus.freeze_clk), 32'd1);
    repeat (4) cycle(9'h000, 1'b1);
    chk("freeze_at_24", 32'(bus.freeze_clk), 32'd1);
    cycle(9'h000, 1'b1);
    chk("freeze_at_23", 32'(bus.freeze_clk), 32'd0);

    // Overflow at count 30, then writes while full
    rand_lanes(); cycle(9'h07F, 1'b0);
    chk("ovf_before", 32'(bus.ovf), 32'd0);
    rand_lanes(); cycle(9'h1FF, 1'b0);
    chk("ovf_set", 32'(bus.ovf), 32'd1);
`ifdef MULTI_WR_FIFO_DROP_CNT_EN
    chk("drop_cnt_7", 32'(bus.drop_cnt), 32'd7);
`endif
    rand_lanes(); cycle(9'h1FF, 1'b1);
    chk("ovf_sticky", 32'(bus.ovf), 32'd1);
    while (q.size() > 12) cycle(9'h000, 1'b1);

    // Asynchronous reset in the middle of a burst
    rand_lanes();
    drive(9'h1FF, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk("async_valid", 32'(bus.valid), 32'd0);
    chk("async_freeze", 32'(bus.freeze_clk), 32'd0);
    chk("async_ovf", 32'(bus.ovf), 32'd0);
    drive(9'h000, 1'b0);
    #1;
    reset = 1'b0;
    q.delete();
    ovf_m  = 1'b0;
    drop_m = 0;
    lanes = '0;
    lanes[27 +: 9] = 9'h055;
    cycle(9'h008, 1'b0);
    chk("post_rst_data", 32'(bus.o_data), 32'h055);
    cycle(9'h000, 1'b1);
    chk("post_rst_empty", 32'(bus.valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
